// File: rtl/charge_timer.sv
// Countdown engine behind the charger controller: idle countdown or paid charging countdown, with end pulse.
// Optional macro CHARGE_PAUSE_EN adds a `pause` input that freezes the charging countdown.
module charge_timer #(
    parameter int CLK_HZ        = 1000,
    parameter int IDLE_SECS     = 10,
    parameter int SECS_PER_UNIT = 2
) (
    input  logic        clk,
    input  logic        init_reset_n,
    input  logic        timer_reset,
    input  logic        timing,
    input  logic        state_timing,
    input  logic [3:0]  amount_tens,
    input  logic [3:0]  amount_ones,
`ifdef CHARGE_PAUSE_EN
    input  logic        pause,
`endif
    output logic        end_timing,
    output logic [15:0] remain,
    output logic        busy,
    output logic        sec_tick
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_HZ - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        CHARGE
    } state_t;

    state_t        state, state_d;
    logic [PW-1:0] prescaler, prescaler_d;
    logic [15:0]   remain_d;
    logic          end_d;
    logic          timing_q, state_timing_q;
    logic          charge_rise, wait_rise;
    logic          frozen;
    logic          do_count;
    logic [15:0]   pay_secs;

    assign charge_rise = timing & ~timing_q;
    assign wait_rise   = state_timing & ~state_timing_q;
    assign busy        = (state != IDLE);

    // 16-bit arithmetic is wide enough: 99 units (or 165 with out-of-range digits) times SECS_PER_UNIT.
    assign pay_secs = (16'(amount_tens) * 16'd10 + 16'(amount_ones)) * 16'(SECS_PER_UNIT);

`ifdef CHARGE_PAUSE_EN
    assign frozen = pause && (state == CHARGE);
`else
    assign frozen = 1'b0;
`endif

    always_ff @(posedge clk or negedge init_reset_n) begin
        if (!init_reset_n) begin
            state          <= IDLE;
            remain         <= 16'd0;
            prescaler      <= '0;
            end_timing     <= 1'b0;
            timing_q       <= 1'b0;
            state_timing_q <= 1'b0;
        end else if (timer_reset) begin
            state          <= IDLE;
            remain         <= 16'd0;
            prescaler      <= '0;
            end_timing     <= 1'b0;
            timing_q       <= 1'b0;
            state_timing_q <= 1'b0;
        end else begin
            state          <= state_d;
            remain         <= remain_d;
            prescaler      <= prescaler_d;
            end_timing     <= end_d;
            timing_q       <= timing;
            state_timing_q <= state_timing;
        end
    end

    // Start/abort decisions first, then the shared per-second countdown step for WAIT and CHARGE.
    always_comb begin
        state_d     = state;
        remain_d    = remain;
        prescaler_d = prescaler;
        end_d       = 1'b0;
        sec_tick    = 1'b0;
        do_count    = 1'b0;

        if (!timer_reset) begin
            case (state)
                IDLE: begin
                    if (charge_rise) begin
                        state_d     = CHARGE;
                        remain_d    = pay_secs;
                        prescaler_d = '0;
                    end else if (wait_rise) begin
                        state_d     = WAIT;
                        remain_d    = 16'(IDLE_SECS);
                        prescaler_d = '0;
                    end
                end
                WAIT: begin
                    if (charge_rise) begin
                        state_d     = CHARGE;
                        remain_d    = pay_secs;
                        prescaler_d = '0;
                    end else if (!state_timing) begin
                        state_d     = IDLE;
                        remain_d    = 16'd0;
                        prescaler_d = '0;
                    end else begin
                        do_count = 1'b1;
                    end
                end
                CHARGE: begin
                    if (!timing) begin
                        state_d     = IDLE;
                        remain_d    = 16'd0;
                        prescaler_d = '0;
                    end else if (!frozen) begin
                        do_count = 1'b1;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    remain_d    = 16'd0;
                    prescaler_d = '0;
                end
            endcase

            if (do_count) begin
                if (remain == 16'd0) begin
                    end_d       = 1'b1;
                    state_d     = IDLE;
                    prescaler_d = '0;
                end else if (prescaler == PRE_LAST) begin
                    sec_tick    = 1'b1;
                    prescaler_d = '0;
                    remain_d    = remain - 16'd1;
                    if (remain == 16'd1) begin
                        end_d   = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    prescaler_d = prescaler + PW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_charge_timer.sv
// Directed bench for charge_timer with CLK_HZ=4, SECS_PER_UNIT=2, IDLE_SECS=10.
// Define CHARGE_PAUSE_EN for both files to exercise the pause scenario.
module tb_charge_timer;

    logic        clk = 1'b0;
    logic        init_reset_n;
    logic        timer_reset;
    logic        timing;
    logic        state_timing;
    logic [3:0]  amount_tens;
    logic [3:0]  amount_ones;
`ifdef CHARGE_PAUSE_EN
    logic        pause;
`endif
    logic        end_timing;
    logic [15:0] remain;
    logic        busy;
    logic        sec_tick;

    int total = 0;
    int bad   = 0;

    charge_timer #(
        .CLK_HZ(4),
        .IDLE_SECS(10),
        .SECS_PER_UNIT(2)
    ) dut (
        .clk(clk),
        .init_reset_n(init_reset_n),
        .timer_reset(timer_reset),
        .timing(timing),
        .state_timing(state_timing),
        .amount_tens(amount_tens),
        .amount_ones(amount_ones),
`ifdef CHARGE_PAUSE_EN
        .pause(pause),
`endif
        .end_timing(end_timing),
        .remain(remain),
        .busy(busy),
        .sec_tick(sec_tick)
    );

    always #5 clk = ~clk;

    // One active edge, then settle before sampling or driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        init_reset_n = 1'b0;
        timer_reset  = 1'b0;
        timing       = 1'b0;
        state_timing = 1'b0;
        amount_tens  = 4'd0;
        amount_ones  = 4'd0;
`ifdef CHARGE_PAUSE_EN
        pause        = 1'b0;
`endif
        #12;
        total++; if (remain !== 16'd0)  begin bad++; $display("[TB] FAIL reset_remain got=%0d want=0", remain); end
        total++; if (busy !== 1'b0)     begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
        total++; if (end_timing !== 1'b0) begin bad++; $display("[TB] FAIL reset_end got=%b want=0", end_timing); end
        total++; if (sec_tick !== 1'b0) begin bad++; $display("[TB] FAIL reset_tick got=%b want=0", sec_tick); end
        init_reset_n = 1'b1;
        step();
        step();
    endtask

    task automatic test_charge();
        int end_k = -1;
        int n_end = 0;
        int n_sec = 0;
        amount_tens = 4'd1;
        amount_ones = 4'd2;
        timing      = 1'b1;
        step();
        total++; if (remain !== 16'd24) begin bad++; $display("[TB] FAIL charge_load got=%0d want=24", remain); end
        total++; if (busy !== 1'b1)     begin bad++; $display("[TB] FAIL charge_busy got=%b want=1", busy); end
        for (int k = 1; k <= 110; k++) begin
            step();
            if (end_timing) begin n_end++; if (end_k < 0) end_k = k; end
            if (sec_tick) n_sec++;
            if (k == 3) begin
                total++; if (sec_tick !== 1'b1) begin bad++; $display("[TB] FAIL charge_first_tick got=%b want=1", sec_tick); end
            end
            if (k == 4) begin
                total++; if (remain !== 16'd23) begin bad++; $display("[TB] FAIL charge_first_dec got=%0d want=23", remain); end
            end
        end
        total++; if (end_k !== 96)  begin bad++; $display("[TB] FAIL charge_end_cycle got=%0d want=96", end_k); end
        total++; if (n_end !== 1)   begin bad++; $display("[TB] FAIL charge_end_count got=%0d want=1", n_end); end
        total++; if (n_sec !== 24)  begin bad++; $display("[TB] FAIL charge_tick_count got=%0d want=24", n_sec); end
        total++; if (remain !== 16'd0) begin bad++; $display("[TB] FAIL charge_final_remain got=%0d want=0", remain); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL charge_final_busy got=%b want=0", busy); end
        timing = 1'b0;
        step();
    endtask

    task automatic test_wait();
        int end_k = -1;
        int n_end = 0;
        state_timing = 1'b1;
        step();
        total++; if (remain !== 16'd10) begin bad++; $display("[TB] FAIL wait_load got=%0d want=10", remain); end
        for (int k = 1; k <= 80; k++) begin
            step();
            if (end_timing) begin n_end++; if (end_k < 0) end_k = k; end
        end
        total++; if (end_k !== 40) begin bad++; $display("[TB] FAIL wait_end_cycle got=%0d want=40", end_k); end
        total++; if (n_end !== 1)  begin bad++; $display("[TB] FAIL wait_retrigger got=%0d want=1", n_end); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL wait_final_busy got=%b want=0", busy); end
        state_timing = 1'b0;
        step();
    endtask

    task automatic test_abort();
        int n_end = 0;
        int n_sec = 0;
        state_timing = 1'b1;
        step();
        for (int k = 1; k <= 12; k++) step();
        total++; if (remain !== 16'd7) begin bad++; $display("[TB] FAIL abort_pre got=%0d want=7", remain); end
        state_timing = 1'b0;
        step();
        total++; if (remain !== 16'd0) begin bad++; $display("[TB] FAIL abort_remain got=%0d want=0", remain); end
        total++; if (busy !== 1'b0)    begin bad++; $display("[TB] FAIL abort_busy got=%b want=0", busy); end
        if (end_timing) n_end++;
        for (int k = 0; k < 50; k++) begin
            step();
            if (end_timing) n_end++;
            if (sec_tick) n_sec++;
        end
        total++; if (n_end !== 0) begin bad++; $display("[TB] FAIL abort_no_end got=%0d want=0", n_end); end
        total++; if (n_sec !== 0) begin bad++; $display("[TB] FAIL abort_no_tick got=%0d want=0", n_sec); end
    endtask

    task automatic test_zero_load();
        int n_sec = 0;
        amount_tens = 4'd0;
        amount_ones = 4'd0;
        timing      = 1'b1;
        step();
        if (sec_tick) n_sec++;
        total++; if (busy !== 1'b1)       begin bad++; $display("[TB] FAIL zero_busy got=%b want=1", busy); end
        total++; if (end_timing !== 1'b0) begin bad++; $display("[TB] FAIL zero_early_end got=%b want=0", end_timing); end
        step();
        if (sec_tick) n_sec++;
        total++; if (end_timing !== 1'b1) begin bad++; $display("[TB] FAIL zero_end got=%b want=1", end_timing); end
        total++; if (busy !== 1'b0)       begin bad++; $display("[TB] FAIL zero_idle got=%b want=0", busy); end
        step();
        if (sec_tick) n_sec++;
        total++; if (end_timing !== 1'b0) begin bad++; $display("[TB] FAIL zero_end_width got=%b want=0", end_timing); end
        total++; if (n_sec !== 0)         begin bad++; $display("[TB] FAIL zero_no_tick got=%0d want=0", n_sec); end
        timing = 1'b0;
        step();
    endtask

    task automatic test_timer_reset();
        amount_tens = 4'd0;
        amount_ones = 4'd5;
        timing      = 1'b1;
        step();
        total++; if (remain !== 16'd10) begin bad++; $display("[TB] FAIL treset_load got=%0d want=10", remain); end
        for (int k = 1; k <= 8; k++) step();
        total++; if (remain !== 16'd8) begin bad++; $display("[TB] FAIL treset_pre got=%0d want=8", remain); end
        timer_reset = 1'b1;
        timing      = 1'b0;
        step();
        total++; if (remain !== 16'd0) begin bad++; $display("[TB] FAIL treset_remain got=%0d want=0", remain); end
        total++; if (busy !== 1'b0)    begin bad++; $display("[TB] FAIL treset_busy got=%b want=0", busy); end
        total++; if (end_timing !== 1'b0) begin bad++; $display("[TB] FAIL treset_end got=%b want=0", end_timing); end
        timer_reset = 1'b0;
        step();
        timing = 1'b1;
        step();
        total++; if (remain !== 16'd10) begin bad++; $display("[TB] FAIL treset_reload got=%0d want=10", remain); end
        total++; if (busy !== 1'b1)     begin bad++; $display("[TB] FAIL treset_rebusy got=%b want=1", busy); end
        timing = 1'b0;
        step();
        total++; if (remain !== 16'd0)  begin bad++; $display("[TB] FAIL charge_abort got=%0d want=0", remain); end
        total++; if (end_timing !== 1'b0) begin bad++; $display("[TB] FAIL charge_abort_end got=%b want=0", end_timing); end
    endtask

    task automatic test_back_to_back();
        // Payment during WAIT switches to CHARGE and reloads.
        state_timing = 1'b1;
        step();
        step();
        step();
        amount_tens = 4'd0;
        amount_ones = 4'd3;
        timing      = 1'b1;
        step();
        total++; if (remain !== 16'd6) begin bad++; $display("[TB] FAIL wait_to_charge got=%0d want=6", remain); end
        state_timing = 1'b0;
        step();
        total++; if (remain !== 16'd6) begin bad++; $display("[TB] FAIL charge_ignores_wait got=%0d want=6", remain); end
        total++; if (busy !== 1'b1)    begin bad++; $display("[TB] FAIL charge_ignores_wait_busy got=%b want=1", busy); end
        timing = 1'b0;
        step();
        step();
        // Simultaneous rises: charging wins; digits above 9 used arithmetically.
        amount_tens  = 4'd12;
        amount_ones  = 4'd11;
        timing       = 1'b1;
        state_timing = 1'b1;
        step();
        total++; if (remain !== 16'd262) begin bad++; $display("[TB] FAIL simultaneous_rise got=%0d want=262", remain); end
        timing       = 1'b0;
        state_timing = 1'b0;
        step();
        step();
    endtask

`ifdef CHARGE_PAUSE_EN
    task automatic test_pause();
        int end_k = -1;
        amount_tens = 4'd0;
        amount_ones = 4'd1;
        timing      = 1'b1;
        step();
        total++; if (remain !== 16'd2) begin bad++; $display("[TB] FAIL pause_load got=%0d want=2", remain); end
        for (int k = 1; k <= 30; k++) begin
            pause = (k >= 3) && (k <= 12);
            step();
            if (end_timing && end_k < 0) end_k = k;
            if (k == 13) begin
                total++; if (remain !== 16'd2) begin bad++; $display("[TB] FAIL pause_frozen got=%0d want=2", remain); end
            end
        end
        pause = 1'b0;
        total++; if (end_k !== 18) begin bad++; $display("[TB] FAIL pause_end_cycle got=%0d want=18", end_k); end
        timing = 1'b0;
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_charge();
        test_wait();
        test_abort();
        test_zero_load();
        test_timer_reset();
        test_back_to_back();
`ifdef CHARGE_PAUSE_EN
        test_pause();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
